// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel counters plus registered, mutually aligned sync/blank/frame markers.
// Define VGA_SYNC_TICK_DIV2_EN to advance the raster every second clk; otherwise it advances every clk.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;
  logic       tick_reg, tick_next;
  logic       hsync_reg, vsync_reg, video_on_reg, frame_start_reg;
  logic       hs_active, vs_active, visible, wrap;

`ifdef VGA_SYNC_TICK_DIV2_EN
  assign tick_next = ~tick_reg;
`else
  assign tick_next = 1'b1;
`endif

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (tick_reg) begin
      if (x_reg == H_LAST) begin
        x_next = 10'd0;
        if (y_reg == V_LAST) begin
          y_next = 10'd0;
        end else begin
          y_next = y_reg + 10'd1;
        end
      end else begin
        x_next = x_reg + 10'd1;
      end
    end
  end

  // Decode the next-state coordinates so the registered markers line up with the counters.
  always_comb begin
    hs_active = (int'(x_next) >= HS_START) && (int'(x_next) < HS_END);
    vs_active = (int'(y_next) >= VS_START) && (int'(y_next) < VS_END);
    visible   = (int'(x_next) < H_ACTIVE) && (int'(y_next) < V_ACTIVE);
    wrap      = tick_reg && (x_reg == H_LAST) && (y_reg == V_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg           <= 10'd0;
      y_reg           <= 10'd0;
      tick_reg        <= 1'b0;
      hsync_reg       <= ~SYNC_ACT;
      vsync_reg       <= ~SYNC_ACT;
      video_on_reg    <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      x_reg           <= x_next;
      y_reg           <= y_next;
      tick_reg        <= tick_next;
      hsync_reg       <= hs_active ? SYNC_ACT : ~SYNC_ACT;
      vsync_reg       <= vs_active ? SYNC_ACT : ~SYNC_ACT;
      video_on_reg    <= visible;
      frame_start_reg <= wrap;
    end
  end

  assign pixel_x     = x_reg;
  assign pixel_y     = y_reg;
  assign pixel_tick  = tick_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a 640x480 instance for line timing and a tiny 12x7 instance for frames.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_TICK_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif
  localparam int EDGE_X639 = (DIV == 2) ? 1279 : 640;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_s = 1'b1;

  logic [9:0] pixel_x, pixel_y;
  logic       hsync, vsync, video_on, pixel_tick, frame_start;
  logic [9:0] px_s, py_s;
  logic       hs_s, vs_s, von_s, tick_s, fs_s;

  int errors = 0;
  int checks = 0;
  int k_big = 0;
  int k_sm = 0;

  vga_sync_gen dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_tick(pixel_tick), .frame_start(frame_start)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1)
  ) dut_s (
    .clk(clk), .reset(reset_s), .pixel_x(px_s), .pixel_y(py_s),
    .hsync(hs_s), .vsync(vs_s), .video_on(von_s),
    .pixel_tick(tick_s), .frame_start(fs_s)
  );

  always #5 clk = ~clk;

  // Pixel ticks consumed after k clk edges since reset release.
  function automatic int ticks_after(input int k);
    if (DIV == 2) return k / 2;
    return (k < 1) ? 0 : k - 1;
  endfunction

  function automatic logic tick_exp(input int k);
    if (DIV == 2) return (k % 2) == 1;
    return 1'b1;
  endfunction

  function automatic void exp_big(input int t, output logic [9:0] ex, output logic [9:0] ey,
                                  output logic eh, output logic ev, output logic eo);
    int x, y;
    x  = t % 800;
    y  = (t / 800) % 525;
    ex = 10'(x);
    ey = 10'(y);
    eh = !(x >= 656 && x < 752);
    ev = !(y >= 490 && y < 492);
    eo = (x < 640) && (y < 480);
  endfunction

  function automatic void exp_small(input int t, output logic [9:0] ex, output logic [9:0] ey,
                                    output logic eh, output logic ev, output logic eo);
    int x, y;
    x  = t % 12;
    y  = (t / 12) % 7;
    ex = 10'(x);
    ey = 10'(y);
    eh = (x == 9) || (x == 10);
    ev = (y == 5);
    eo = (x < 8) && (y < 4);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({pixel_x, pixel_y} !== 20'd0) begin
      errors++;
      $display("FAIL reset_xy got x=%0d y=%0d want 0/0", pixel_x, pixel_y);
    end
    checks++;
    if ({hsync, vsync} !== 2'b11) begin
      errors++;
      $display("FAIL reset_sync got hs=%b vs=%b want 1/1", hsync, vsync);
    end
    checks++;
    if ({video_on, pixel_tick, frame_start} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got von/tick/fs=%b%b%b want 000", video_on, pixel_tick, frame_start);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({video_on, pixel_tick, pixel_x} !== {1'b1, 1'b1, 10'd0}) begin
      errors++;
      $display("FAIL first_edge got von=%b tick=%b x=%0d want 1/1/0", video_on, pixel_tick, pixel_x);
    end
    @(posedge clk); #1;
    checks++;
    if (pixel_x !== 10'd1) begin
      errors++;
      $display("FAIL second_edge_x got %0d want 1", pixel_x);
    end
    k_big = 2;
  endtask

  task automatic test_line();
    int t, hs_low, fall_x;
    logic von_prev;
    logic [9:0] ex, ey;
    logic eh, ev, eo, ek;
    hs_low   = 0;
    fall_x   = -1;
    von_prev = video_on;
    while (ticks_after(k_big) < 805) begin
      @(posedge clk); #1;
      k_big++;
      t = ticks_after(k_big);
      exp_big(t, ex, ey, eh, ev, eo);
      ek = tick_exp(k_big);
      checks++;
      if ({pixel_x, pixel_y, hsync, vsync, video_on, pixel_tick, frame_start} !==
          {ex, ey, eh, ev, eo, ek, 1'b0}) begin
        errors++;
        if (errors <= 40)
          $display("FAIL line t=%0d x/y/hs/vs/von/tick/fs got %0d/%0d/%b/%b/%b/%b/%b want %0d/%0d/%b/%b/%b/%b/0",
                   t, pixel_x, pixel_y, hsync, vsync, video_on, pixel_tick, frame_start,
                   ex, ey, eh, ev, eo, ek);
      end
      if (t < 800 && hsync === 1'b0) hs_low++;
      if (fall_x < 0 && von_prev === 1'b1 && video_on === 1'b0) fall_x = int'(pixel_x);
      von_prev = video_on;
      if (k_big == EDGE_X639) begin
        checks++;
        if (pixel_x !== 10'd639) begin
          errors++;
          $display("FAIL x639_edge got %0d want 639", pixel_x);
        end
      end
    end
    checks++;
    if (hs_low != 96 * DIV) begin
      errors++;
      $display("FAIL hsync_width got %0d clk want %0d", hs_low, 96 * DIV);
    end
    checks++;
    if (fall_x != 640) begin
      errors++;
      $display("FAIL video_on_fall got x=%0d want 640", fall_x);
    end
  endtask

  task automatic test_mid_reset();
    int t;
    logic [9:0] ex, ey;
    logic eh, ev, eo, ek;
    while (ticks_after(k_big) < 1200) begin
      @(posedge clk); #1;
      k_big++;
    end
    checks++;
    if ({pixel_x, pixel_y} !== {10'd400, 10'd1}) begin
      errors++;
      $display("FAIL pre_reset_pos got %0d,%0d want 400,1", pixel_x, pixel_y);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({pixel_x, pixel_y, hsync, vsync, video_on, pixel_tick, frame_start} !==
        {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got x=%0d y=%0d hs=%b vs=%b von=%b tick=%b fs=%b want 0/0/1/1/0/0/0",
               pixel_x, pixel_y, hsync, vsync, video_on, pixel_tick, frame_start);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    k_big = 0;
    repeat (20) begin
      @(posedge clk); #1;
      k_big++;
      t = ticks_after(k_big);
      exp_big(t, ex, ey, eh, ev, eo);
      ek = tick_exp(k_big);
      checks++;
      if ({pixel_x, pixel_y, hsync, vsync, video_on, pixel_tick, frame_start} !==
          {ex, ey, eh, ev, eo, ek, 1'b0}) begin
        errors++;
        if (errors <= 40)
          $display("FAIL restart t=%0d x/y/von/tick/fs got %0d/%0d/%b/%b/%b want %0d/%0d/%b/%b/0",
                   t, pixel_x, pixel_y, video_on, pixel_tick, frame_start, ex, ey, eo, ek);
      end
    end
  endtask

  task automatic test_small_frame();
    int t, tprev, pulses, last_k, vs_clk;
    logic [9:0] ex, ey;
    logic eh, ev, eo, ek, ef;
    pulses = 0;
    last_k = -1;
    vs_clk = 0;
    @(posedge clk); #1;
    reset_s = 1'b0;
    k_sm  = 0;
    tprev = 0;
    repeat (3 * 84 * DIV + 4) begin
      @(posedge clk); #1;
      k_sm++;
      t = ticks_after(k_sm);
      exp_small(t, ex, ey, eh, ev, eo);
      ek = tick_exp(k_sm);
      ef = (t != tprev) && (t % 84 == 0);
      tprev = t;
      checks++;
      if ({px_s, py_s, hs_s, vs_s, von_s, tick_s, fs_s} !== {ex, ey, eh, ev, eo, ek, ef}) begin
        errors++;
        if (errors <= 40)
          $display("FAIL small t=%0d x/y/hs/vs/von/tick/fs got %0d/%0d/%b/%b/%b/%b/%b want %0d/%0d/%b/%b/%b/%b/%b",
                   t, px_s, py_s, hs_s, vs_s, von_s, tick_s, fs_s, ex, ey, eh, ev, eo, ek, ef);
      end
      if (t < 84 && vs_s === 1'b1) vs_clk++;
      if (fs_s === 1'b1) begin
        pulses++;
        if (last_k >= 0) begin
          checks++;
          if (k_sm - last_k != 84 * DIV) begin
            errors++;
            $display("FAIL frame_interval got %0d clk want %0d", k_sm - last_k, 84 * DIV);
          end
        end
        last_k = k_sm;
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL frame_pulses got %0d want 3", pulses);
    end
    checks++;
    if (vs_clk != 12 * DIV) begin
      errors++;
      $display("FAIL vsync_width got %0d clk want %0d", vs_clk, 12 * DIV);
    end
  endtask

  task automatic test_small_mid_reset();
    int t, tprev, pulses;
    logic [9:0] ex, ey;
    logic eh, ev, eo, ek, ef;
    while (ticks_after(k_sm) < 300) begin
      @(posedge clk); #1;
      k_sm++;
    end
    checks++;
    if ({px_s, py_s} !== {10'd0, 10'd4}) begin
      errors++;
      $display("FAIL small_pre_reset got %0d,%0d want 0,4", px_s, py_s);
    end
    reset_s = 1'b1;
    #1;
    checks++;
    if ({px_s, py_s, hs_s, vs_s, von_s, tick_s, fs_s} !==
        {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL small_async_reset got x=%0d y=%0d hs=%b vs=%b von=%b tick=%b fs=%b want 0/0/0/0/0/0/0",
               px_s, py_s, hs_s, vs_s, von_s, tick_s, fs_s);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_s = 1'b0;
    k_sm   = 0;
    tprev  = 0;
    pulses = 0;
    repeat (84 * DIV + 2) begin
      @(posedge clk); #1;
      k_sm++;
      t = ticks_after(k_sm);
      exp_small(t, ex, ey, eh, ev, eo);
      ek = tick_exp(k_sm);
      ef = (t != tprev) && (t % 84 == 0);
      tprev = t;
      checks++;
      if ({px_s, py_s, hs_s, vs_s, von_s, tick_s, fs_s} !== {ex, ey, eh, ev, eo, ek, ef}) begin
        errors++;
        if (errors <= 40)
          $display("FAIL small_restart t=%0d x/y/von/fs got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                   t, px_s, py_s, von_s, fs_s, ex, ey, eo, ef);
      end
      if (fs_s === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL restart_pulses got %0d want 1", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_mid_reset();
    test_small_frame();
    test_small_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
